// File: rtl/servo_sweep_pkg.sv
// Shared sweep definitions: FSM state encodings and direction constants.
// Imported by the servo sweep sequencer and its timer.
package udar_defs;

  typedef enum logic [1:0] {
    SWEEP_IDLE   = 2'd0,
    SWEEP_SETTLE = 2'd1,
    SWEEP_REQ    = 2'd2,
    SWEEP_WAIT   = 2'd3
  } sweep_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/servo_sweep_timer.sv
// Loadable down-counter shared by settle dwell and measurement timeout.
// Saturates at zero; zero is asserted while the count reads 0.
module sweep_timer #(
  parameter int CNT_LEN = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [CNT_LEN-1:0] value,
  output logic               zero
);

  logic [CNT_LEN-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/servo_sweep.sv
// Servo sweep sequencer: steps pos between limits, settles, requests a range sample.
// Optional measurement timeout via SERVO_SWEEP_TIMEOUT_EN.
module servo_sweep
  import udar_defs::*;
#(
  parameter int POS_LEN     = 8,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 180,
  parameter int STEP        = 1,
  parameter int CNT_LEN     = 20,
  parameter int SETTLE_CYC  = 500000,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               meas_done,
  output logic [POS_LEN-1:0] pos,
  output logic               dir,
  output logic               meas_req,
  output logic               sweep_done,
  output logic               busy,
  output logic               timeout
);

  localparam logic [CNT_LEN-1:0] SETTLE_LD =
    CNT_LEN'(SETTLE_CYC - 1);
  localparam logic [CNT_LEN-1:0] TMO_LD =
    CNT_LEN'(TIMEOUT_CYC - 1);

  localparam logic [POS_LEN-1:0] MIN_P  = POS_LEN'(POS_MIN);
  localparam logic [POS_LEN-1:0] MAX_P  = POS_LEN'(POS_MAX);
  localparam logic [POS_LEN-1:0] STEP_P = POS_LEN'(STEP);
  localparam logic [POS_LEN:0]   MAX_X  = (POS_LEN+1)'(POS_MAX);
  localparam logic [POS_LEN:0]   STEP_X = (POS_LEN+1)'(STEP);
  localparam logic [POS_LEN:0]   FLOOR_X =
    (POS_LEN+1)'(POS_MIN + STEP);

  sweep_state_t state, nxt;

  logic [POS_LEN-1:0] pos_q, pos_n;
  logic               dir_q, dir_n;
  logic               req_q;
  logic               sd_q;
  logic               busy_q;

  logic               load;
  logic [CNT_LEN-1:0] ld_val;
  logic               zero;
  logic               ack;
  logic               step;
  logic               rev;

  logic [POS_LEN:0]   pos_x;
  logic [POS_LEN:0]   up_x;
  logic [POS_LEN-1:0] up_p;
  logic [POS_LEN-1:0] dn_p;

  sweep_timer #(
    .CNT_LEN (CNT_LEN)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .value (ld_val),
    .zero  (zero)
  );

  // Clamped neighbours in POS_LEN+1 bits so nothing wraps.
  always_comb begin
    pos_x = {1'b0, pos_q};
    up_x  = pos_x + STEP_X;
    up_p  = (up_x > MAX_X) ? MAX_P : up_x[POS_LEN-1:0];
    dn_p  = (pos_x < FLOOR_X) ? MIN_P : pos_q - STEP_P;
  end

  always_comb begin
    dir_n = dir_q;
    pos_n = pos_q;
    rev   = 1'b0;
    if (dir_q == DIR_UP) begin
      if (pos_q == MAX_P) begin
        dir_n = DIR_DOWN;
        pos_n = dn_p;
        rev   = 1'b1;
      end else begin
        pos_n = up_p;
      end
    end else begin
      if (pos_q == MIN_P) begin
        dir_n = DIR_UP;
        pos_n = up_p;
        rev   = 1'b1;
      end else begin
        pos_n = dn_p;
      end
    end
  end

`ifdef SERVO_SWEEP_TIMEOUT_EN
  logic expire;
  logic tmo_q;
  assign expire = (state == SWEEP_WAIT) && zero && !meas_done;
  assign ack    = meas_done || expire;
`else
  assign ack    = meas_done;
`endif

  always_comb begin
    nxt    = state;
    load   = 1'b0;
    ld_val = (state == SWEEP_REQ) ? TMO_LD : SETTLE_LD;
    step   = 1'b0;
    unique case (state)
      SWEEP_IDLE: begin
        if (en) begin
          nxt  = SWEEP_SETTLE;
          load = 1'b1;
        end
      end
      SWEEP_SETTLE: begin
        if (zero) nxt = SWEEP_REQ;
      end
      SWEEP_REQ: begin
        nxt = SWEEP_WAIT;
`ifdef SERVO_SWEEP_TIMEOUT_EN
        load = 1'b1;
`endif
      end
      SWEEP_WAIT: begin
        if (ack) begin
          if (en) begin
            nxt  = SWEEP_SETTLE;
            load = 1'b1;
            step = 1'b1;
          end else begin
            nxt = SWEEP_IDLE;
          end
        end
      end
      default: nxt = SWEEP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= SWEEP_IDLE;
      pos_q  <= MIN_P;
      dir_q  <= DIR_UP;
      req_q  <= 1'b0;
      sd_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= nxt;
      req_q  <= (nxt == SWEEP_REQ);
      sd_q   <= step && rev;
      busy_q <= (nxt != SWEEP_IDLE);
      if (step) begin
        pos_q <= pos_n;
        dir_q <= dir_n;
      end
    end
  end

`ifdef SERVO_SWEEP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= expire;
    end
  end
  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign pos        = pos_q;
  assign dir        = dir_q;
  assign meas_req   = req_q;
  assign sweep_done = sd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_servo_sweep.sv
// Directed bench for servo_sweep: step timing, bounce table, ignored acks,
// enable drop, timeout (when SERVO_SWEEP_TIMEOUT_EN is defined) and reset.
module tb_servo_sweep;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       meas_done = 1'b0;

  logic [7:0] pos_b, pos_s;
  logic       dir_b, dir_s;
  logic       req_b, req_s;
  logic       sd_b, sd_s;
  logic       busy_b, busy_s;
  logic       tmo_b, tmo_s;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  servo_sweep #(
    .POS_LEN(8), .POS_MIN(0), .POS_MAX(5), .STEP(2),
    .CNT_LEN(8), .SETTLE_CYC(4), .TIMEOUT_CYC(8)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .meas_done(meas_done),
    .pos(pos_b), .dir(dir_b), .meas_req(req_b),
    .sweep_done(sd_b), .busy(busy_b), .timeout(tmo_b)
  );

  servo_sweep #(
    .POS_LEN(8), .POS_MIN(0), .POS_MAX(180), .STEP(1),
    .CNT_LEN(8), .SETTLE_CYC(4), .TIMEOUT_CYC(8)
  ) u_s (
    .clk(clk), .rst(rst), .en(en), .meas_done(meas_done),
    .pos(pos_s), .dir(dir_s), .meas_req(req_s),
    .sweep_done(sd_s), .busy(busy_s), .timeout(tmo_s)
  );

  typedef struct {
    int pos;
    int dir;
    int sd;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until meas_req is seen (bounded); returns edges elapsed.
  task automatic wait_req(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!req_b && n < 40);
    chk("req_seen", int'(req_b), 1);
  endtask

  task automatic ack();
    meas_done = 1'b1;
    tick();
    meas_done = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    tbl[0] = '{4, 1, 0};
    tbl[1] = '{5, 1, 0};
    tbl[2] = '{3, 0, 1};
    tbl[3] = '{1, 0, 0};
    tbl[4] = '{0, 0, 0};
    tbl[5] = '{2, 1, 1};

    repeat (3) tick();
    chk("rst_pos", int'(pos_b), 0);
    chk("rst_dir", int'(dir_b), 1);
    chk("rst_busy", int'(busy_b), 0);
    chk("rst_req", int'(req_b), 0);
    chk("rst_sd", int'(sd_b), 0);
    chk("rst_tmo", int'(tmo_b), 0);
    rst = 1'b1;
    tick();

    // Single step: meas_req four edges after busy rises.
    en = 1'b1;
    tick();
    chk("busy_rise", int'(busy_b), 1);
    chk("req_early", int'(req_b), 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("req_t%0d", i), int'(req_b), (i == 4) ? 1 : 0);
    end
    tick();
    chk("req_one_cycle", int'(req_b), 0);
    ack();
    chk("step_pos_s", int'(pos_s), 1);
    chk("step_pos_b", int'(pos_b), 2);
    chk("step_dir", int'(dir_b), 1);
    chk("step_sd", int'(sd_b), 0);
    chk("step_busy", int'(busy_b), 1);

    // Non-aligned bounce with immediate ack.
    for (int k = 0; k < 6; k++) begin
      wait_req(n);
      chk($sformatf("gap_%0d", k), n, 4);
      tick();
      ack();
      chk($sformatf("bpos_%0d", k), int'(pos_b), tbl[k].pos);
      chk($sformatf("bdir_%0d", k), int'(dir_b), tbl[k].dir);
      chk($sformatf("bsd_%0d", k), int'(sd_b), tbl[k].sd);
    end
    tick();
    chk("sd_one_cycle", int'(sd_b), 0);

    // Acks during SETTLE and REQ are ignored.
    meas_done = 1'b1;
    wait_req(n);
    tick();
    meas_done = 1'b0;
    chk("ign_req", int'(req_b), 0);
    chk("ign_pos", int'(pos_b), 2);
    chk("ign_busy", int'(busy_b), 1);
    repeat (2) tick();
    chk("ign_hold", int'(pos_b), 2);
    ack();
    chk("ign_step", int'(pos_b), 4);

    // Enable drop during SETTLE: finish this sample, then idle.
    en = 1'b0;
    wait_req(n);
    tick();
    ack();
    chk("drop_pos", int'(pos_b), 4);
    chk("drop_busy", int'(busy_b), 0);
    chk("drop_sd", int'(sd_b), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_b || busy_b) cnt++;
    end
    chk("drop_quiet", cnt, 0);

    en = 1'b1;
`ifdef SERVO_SWEEP_TIMEOUT_EN
    wait_req(n);
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("tmo_t%0d", i), int'(tmo_b), (i == 8) ? 1 : 0);
    end
    chk("tmo_pos", int'(pos_b), 5);
    tick();
    chk("tmo_pulse", int'(tmo_b), 0);
    wait_req(n);
    tick();
    repeat (7) tick();
    ack();
    chk("tmo_same_cycle", int'(tmo_b), 0);
    chk("tmo_same_pos", int'(pos_b), 3);
    chk("tmo_same_sd", int'(sd_b), 1);
`else
    wait_req(n);
    tick();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tmo_b || pos_b != 8'd4) cnt++;
    end
    chk("wait_hold", cnt, 0);
    ack();
    chk("wait_step", int'(pos_b), 5);
`endif

    // Asynchronous reset in WAIT.
    wait_req(n);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_pos", int'(pos_b), 0);
    chk("arst_dir", int'(dir_b), 1);
    chk("arst_busy", int'(busy_b), 0);
    chk("arst_req", int'(req_b), 0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_b || busy_b) cnt++;
    end
    chk("arst_quiet", cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/servo_sweep.md
# servo_sweep

Sweep sequencer that sits directly upstream of the servo PWM stage and drives its position input. It steps `pos` back and forth between two limits, waits a settle time at each step, pulses a measurement request to the ranging logic, and advances only after the measurement completes. The result is a full angular scan with one range sample per position.

## Interface
Parameters:
- `POS_LEN`, 8: width of `pos`; matches the servo position input.
- `POS_MIN`, 0: lower sweep limit.
- `POS_MAX`, 180: upper sweep limit. Constraint: `POS_MIN < POS_MAX < 2**POS_LEN`.
- `STEP`, 1: position increment. Constraint: `1 ≤ STEP ≤ POS_MAX-POS_MIN`.
- `CNT_LEN`, 20: width of the dwell/timeout counter.
- `SETTLE_CYC`, 500000: settle time in clk cycles. Constraint: `1 ≤ SETTLE_CYC < 2**CNT_LEN`.
- `TIMEOUT_CYC`, 1000000: measurement timeout in clk cycles. Used only under `SERVO_SWEEP_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable, level-sensitive.
- `meas_done`  in  1  single-cycle pulse from the ranging logic when the measurement completes.
- `pos`  out  `POS_LEN`  position command to the servo stage.
- `dir`  out  1  sweep direction: 1 = increasing, 0 = decreasing.
- `meas_req`  out  1  single-cycle measurement request.
- `sweep_done`  out  1  single-cycle pulse on each direction reversal.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `timeout`  out  1  single-cycle pulse when a measurement times out. Tied to 0 without the macro.

## Operation
- FSM states: IDLE, SETTLE, REQ, WAIT.
- **IDLE**
  - `en`=1 → SETTLE; counter loads `SETTLE_CYC-1`.
  - Otherwise hold; `pos` retains its value.
- **SETTLE**
  - Counter decrements each cycle.
  - On the cycle the counter reads 0 → REQ.
  - `en` is ignored here.
- **REQ**
  - `meas_req`=1 for this one cycle.
  - → WAIT unconditionally.
- **WAIT**
  - On `meas_done`=1:
    - If `en`=1: compute next position/direction, → SETTLE, counter reloads.
    - If `en`=0: → IDLE with `pos` unchanged.
  - `meas_done` is ignored in every state other than WAIT.
- **Next-position rule**
  - Arithmetic is done in `POS_LEN+1` bits; no wrap-around.
  - `dir`=1, `pos`==`POS_MAX`: `dir`←0, `pos`←max(`pos`-`STEP`, `POS_MIN`), `sweep_done` pulses.
  - `dir`=1, otherwise: `pos`←min(`pos`+`STEP`, `POS_MAX`).
  - `dir`=0, `pos`==`POS_MIN`: `dir`←1, `pos`←min(`pos`+`STEP`, `POS_MAX`), `sweep_done` pulses.
  - `dir`=0, otherwise: `pos`←max(`pos`-`STEP`, `POS_MIN`).
  - With non-aligned `STEP`, this clamping guarantees both limits are visited.

## Timing
- **Reset values:** state IDLE, `pos`=`POS_MIN`, `dir`=1, counter 0, all pulse outputs 0, `busy`=0.
- **Reset mid-operation** aborts immediately to the reset values; there is no pending request.
- **All outputs are registered.**
- **Cycle counts:**
  - `en` sampled high at edge 0 → `busy`=1 after edge 0.
  - `meas_req` is high in the cycle after edge `SETTLE_CYC`.
  - `meas_done` sampled at edge k → new `pos`, `dir`, `sweep_done` visible after edge k (1-cycle latency).
  - Next `meas_req` follows `SETTLE_CYC`+1 cycles later.
- **`meas_done` coincident with `meas_req`** (REQ cycle) is ignored; the FSM still waits in WAIT.
- **`pos` changes only on a WAIT→SETTLE transition.**

## Configuration
- Macro: `SERVO_SWEEP_TIMEOUT_EN`.
- **Defined:**
  - On entry to WAIT, the counter loads `TIMEOUT_CYC-1`.
  - If it reaches 0 without `meas_done`, `timeout` pulses and the FSM proceeds exactly as if `meas_done` had arrived: it steps, or goes to IDLE if `en`=0.
  - `meas_done` and expiry in the same cycle counts as done; `timeout` stays 0.
- **Undefined:** WAIT holds indefinitely; `timeout` is constant 0; the counter is unused in WAIT.

## Structure
- Shared package/header `udar_defs` holds:
  - the FSM state encodings (`SWEEP_IDLE`, `SWEEP_SETTLE`, `SWEEP_REQ`, `SWEEP_WAIT`);
  - the direction constants `DIR_UP`/`DIR_DOWN`.
- Sub-module `sweep_timer`: loadable down-counter, `CNT_LEN` wide, with `load`/`value`/`zero` ports. It is shared by the settle and timeout functions.
- The top level holds the FSM and the position/direction datapath.

## Test plan
- **Reset:** assert `rst`=0 mid-WAIT → `pos`=`POS_MIN`, `dir`=1, `busy`=0, no `meas_req` after release until `en`.
- **Single step** (`SETTLE_CYC`=4): `en`=1 → `meas_req` pulse 4 cycles after `busy`; `meas_done` → `pos` 0→1 one cycle later.
- **Non-aligned bounce** (`POS_MIN`=0, `POS_MAX`=5, `STEP`=2, auto-ack): `pos` sequence 0,2,4,5,3,1,0,2; `sweep_done` pulses on the 5→3 and 0→2 transitions.
- **Ignored ack:** `meas_done` during SETTLE and during REQ → no state change; the FSM still waits for a WAIT-phase ack.
- **Enable drop:** `en`=0 during SETTLE, then ack → FSM goes to IDLE, `pos` unchanged, no further `meas_req`.
- **Timeout** (macro defined, `TIMEOUT_CYC`=8): no ack → `timeout` pulse 8 cycles after WAIT entry, `pos` advances. Same-cycle ack and expiry → `timeout`=0.
